// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared constants and FSM state type for the SPI register blocks.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int ADDR_W       = 7;
    localparam int CMD_W        = 8;
    localparam int CNT_W        = 6;
    localparam int DEFAULT_NBIT = 8;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        SKIP = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_edge_sync
// Brief    : Oversamples sclk/cs/mosi in the clk domain and detects edges.
// Revision : 1.0 - initial release
// ============================================================================
module spi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic mosi,
    input  logic cs,
    output logic sclk_rise,
    output logic cs_fall,
    output logic cs_high,
    output logic mosi_s
);

    logic [4:0] r_sclk_sync;
    logic [4:0] r_cs_sync;
    logic [2:0] r_mosi_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[3:0], sclk};
            r_cs_sync   <= {r_cs_sync[3:0], cs};
            r_mosi_sync <= {r_mosi_sync[1:0], mosi};
        end
    end

    // mosi tap is two samples deep so it lines up with the sclk rise window
    assign sclk_rise = (r_sclk_sync[2:0] == 3'b001);
    assign cs_fall   = (r_cs_sync[3:1] == 3'b110);
    assign cs_high   = r_cs_sync[2];
    assign mosi_s    = r_mosi_sync[2];

    // Oldest taps are kept for the read block's timing but not consumed here
    logic w_unused;
    assign w_unused = ^{r_sclk_sync[4:3], r_cs_sync[4]};

endmodule
`default_nettype wire

// File: rtl/block_write_spi.sv
`default_nettype none
// ============================================================================
// Module   : block_write_spi
// Brief    : SPI-slave write register; commits an Nbit word on address match.
// Revision : 1.0 - initial release
// ============================================================================
module block_write_spi
    import spi_pkg::*;
#(
    parameter int                Nbit      = DEFAULT_NBIT,
    parameter logic [ADDR_W-1:0] param_adr = 7'd1,
    parameter logic [Nbit-1:0]   RST_VAL   = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sclk,
    input  logic            mosi,
    input  logic            cs,
    output logic [Nbit-1:0] outport,
    output logic            wr_stb,
    output logic            busy
);

    localparam logic [CNT_W-1:0] c_cmd_cnt  = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] c_nbit_cnt = CNT_W'(Nbit);

    logic w_sclk_rise;
    logic w_cs_fall;
    logic w_cs_high;
    logic w_mosi_s;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CMD_W-1:0] r_cmd;
    logic [Nbit-1:0]  r_shift;
    logic [Nbit-1:0]  r_outport;
    logic             r_wr_stb;
    logic             r_busy;

    spi_edge_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs        (cs),
        .sclk_rise (w_sclk_rise),
        .cs_fall   (w_cs_fall),
        .cs_high   (w_cs_high),
        .mosi_s    (w_mosi_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_cmd     <= '0;
            r_shift   <= '0;
            r_outport <= RST_VAL;
            r_wr_stb  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_wr_stb <= 1'b0;
            // A new frame start beats everything, then an abort by cs release
            if (w_cs_fall) begin
                r_state <= ADDR;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else if (w_cs_high && (r_state != IDLE)) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: ;
                    ADDR: begin
                        if (r_cnt == c_cmd_cnt) begin
                            if ((r_cmd[CMD_W-1] == RW_WRITE) &&
                                (r_cmd[ADDR_W-1:0] == param_adr)) begin
                                r_state <= DATA;
                                r_cnt   <= '0;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= SKIP;
                            end
                        end else if (w_sclk_rise) begin
                            r_cmd <= {r_cmd[CMD_W-2:0], w_mosi_s};
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                    DATA: begin
                        if (r_cnt == c_nbit_cnt) begin
                            r_outport <= r_shift;
                            r_wr_stb  <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= SKIP;
                        end else if (w_sclk_rise) begin
                            r_shift <= {r_shift[Nbit-2:0], w_mosi_s};
                            r_cnt   <= r_cnt + 6'd1;
                        end
                    end
                    SKIP: ;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign outport = r_outport;
    assign wr_stb  = r_wr_stb;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_block_write_spi.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_write_spi
// Brief    : Directed, table-driven bench for block_write_spi (Nbit=8, adr=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_write_spi;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       mosi;
    logic       cs;
    logic [7:0] outport;
    logic       wr_stb;
    logic       busy;

    block_write_spi #(
        .Nbit      (8),
        .param_adr (7'd1),
        .RST_VAL   (8'h11)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .mosi    (mosi),
        .cs      (cs),
        .outport (outport),
        .wr_stb  (wr_stb),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int stb_cnt   = 0;
    int stb_cyc   = -1;
    int last_rise = 0;
    bit busy_seen = 1'b0;

    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            stb_cnt = stb_cnt + 1;
            stb_cyc = cyc;
        end
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_mon();
        stb_cnt   = 0;
        stb_cyc   = -1;
        busy_seen = 1'b0;
    endtask

    // Sends the command byte then ndata bits of data, MSB first; cs must already be low
    task automatic shift_bits(input logic [7:0] cmd, input logic [31:0] data, input int ndata);
        logic [39:0] v;
        v = {cmd, data};
        for (int i = 0; i < 8 + ndata; i++) begin
            mosi = v[39-i];
            wait_clk(8);
            sclk      = 1'b1;
            last_rise = cyc;
            wait_clk(8);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [31:0] data, input int ndata);
        cs = 1'b0;
        wait_clk(4);
        shift_bits(cmd, data, ndata);
        wait_clk(8);
        cs = 1'b1;
        wait_clk(8);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] data;
        int          ndata;
        logic [7:0]  exp_out;
        int          exp_stb;
        bit          exp_busy;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{8'h82, 32'h3C000000, 8,  8'h11, 0, 1'b0};  // address mismatch
        vt[1] = '{8'h01, 32'hFF000000, 8,  8'h11, 0, 1'b0};  // read command
        vt[2] = '{8'h81, 32'hA5000000, 8,  8'hA5, 1, 1'b1};  // write
        vt[3] = '{8'h81, 32'h5A000000, 8,  8'h5A, 1, 1'b1};  // write
        vt[4] = '{8'h81, 32'h12345678, 32, 8'h12, 1, 1'b1};  // 24 extra sclks
        vt[5] = '{8'h80, 32'hC3000000, 8,  8'h12, 0, 1'b0};  // write to address 0

        rst  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        cs   = 1'b1;
        wait_clk(3);
        check("reset_outport", 32'(outport), 32'h11);
        check("reset_wr_stb", 32'(wr_stb), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        wait_clk(8);

        // Abort during data: 4 bits then cs released
        clr_mon();
        cs = 1'b0;
        wait_clk(4);
        shift_bits(8'h81, 32'hB0000000, 4);
        check("abort_busy_high", 32'(busy), 32'h1);
        cs = 1'b1;
        wait_clk(6);
        check("abort_busy_low", 32'(busy), 32'h0);
        check("abort_no_stb", 32'(stb_cnt), 32'h0);
        check("abort_outport", 32'(outport), 32'h11);
        wait_clk(8);

        for (int k = 0; k < 6; k++) begin
            clr_mon();
            frame(vt[k].cmd, vt[k].data, vt[k].ndata);
            check($sformatf("vec%0d_outport", k), 32'(outport), 32'(vt[k].exp_out));
            check($sformatf("vec%0d_stb_count", k), 32'(stb_cnt), 32'(vt[k].exp_stb));
            check($sformatf("vec%0d_busy_seen", k), 32'(busy_seen), 32'(vt[k].exp_busy));
            if (vt[k].exp_stb == 1 && vt[k].ndata == 8)
                check($sformatf("vec%0d_stb_latency", k), 32'(stb_cyc - last_rise), 32'd3);
        end

        // Reset in the middle of the data phase
        clr_mon();
        cs = 1'b0;
        wait_clk(4);
        shift_bits(8'h81, 32'hF0000000, 3);
        wait_clk(2);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("midrst_outport", 32'(outport), 32'h11);
        check("midrst_busy", 32'(busy), 32'h0);
        cs = 1'b1;
        wait_clk(8);
        check("midrst_no_stb", 32'(stb_cnt), 32'h0);
        clr_mon();
        frame(8'h81, 32'h42000000, 8);
        check("after_rst_outport", 32'(outport), 32'h42);
        check("after_rst_stb", 32'(stb_cnt), 32'h1);

        // Back-to-back frames with cs high for only 2 clk
        clr_mon();
        cs = 1'b0;
        wait_clk(4);
        shift_bits(8'h81, 32'h12000000, 8);
        wait_clk(8);
        check("b2b_first_outport", 32'(outport), 32'h12);
        check("b2b_first_stb", 32'(stb_cnt), 32'h1);
        cs = 1'b1;
        wait_clk(2);
        cs = 1'b0;
        wait_clk(4);
        shift_bits(8'h81, 32'h34000000, 8);
        wait_clk(8);
        cs = 1'b1;
        wait_clk(8);
        check("b2b_second_outport", 32'(outport), 32'h34);
        check("b2b_total_stb", 32'(stb_cnt), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
